// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer responding to the M-stage IO bus.
//
// Registers (word offset on Addr):
//   0 CTRL   [0] En, [2:1] Mode (01 auto-reload, else one-shot), [3] IM
//   1 PRESET reload value
//   2 COUNT  current count (read-only)
//   3 STATUS {31'b0, irq_flag}, write 1 to bit 0 clears the flag
//            (only with TIMER_IRQ_STATUS_EN defined; otherwise reads 0,
//            writes ignored)
//
// Ports:
//   Clk    system clock, all state changes on posedge
//   Reset  synchronous active-high reset
//   Sel    chip-select from the bridge address decode
//   WE     write strobe, effective write is Sel & WE
//   Addr   word offset (bus address bits [3:2])
//   Din    write data
//   Dout   combinational read data
//   IRQ    level interrupt request, irq_flag gated by CTRL.IM
//
// Optional feature macro: TIMER_IRQ_STATUS_EN
`timescale 1ns/1ps

module timer_dev #(
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Sel,
    input  logic        WE,
    input  logic [1:0]  Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t              state;
    logic [CTRL_W-1:0]   ctrl;
    logic [DATA_W-1:0]   preset;
    logic [DATA_W-1:0]   count;
    logic                irq_flag;

    // Bus write decode
    logic wr;
    logic wr_ctrl;
    logic wr_preset;
    assign wr        = Sel & WE;
    assign wr_ctrl   = wr && (Addr == ADDR_CTRL);
    assign wr_preset = wr && (Addr == ADDR_PRESET);

`ifdef TIMER_IRQ_STATUS_EN
    logic wr_status_clr;
    assign wr_status_clr = wr && (Addr == ADDR_STATUS) && Din[0];
`endif

    logic ctrl_en;
    logic mode_reload;
    logic ctrl_im;
    assign ctrl_en     = ctrl[0];
    assign mode_reload = (ctrl[2:1] == MODE_RELOAD);
    assign ctrl_im     = ctrl[3];

    // Counter FSM plus register file; later assignments take priority,
    // so the order below encodes who wins on a same-cycle collision.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            ctrl     <= '0;
            preset   <= RESET_PRESET;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
`ifdef TIMER_IRQ_STATUS_EN
            // STATUS clear sits before the FSM so a same-cycle set wins.
            if (wr_status_clr) begin
                irq_flag <= 1'b0;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count > DATA_W'(1)) begin
                        count <= count - DATA_W'(1);
                    end else begin
                        // Reaching 1 or starting at 0 both terminate; never wraps.
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (mode_reload) begin
                        // One-cycle pulse; IDLE then reloads since En stays set.
                        irq_flag <= 1'b0;
                    end else begin
                        ctrl[0] <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Bus writes last: they override the FSM on CTRL and irq_flag.
            if (wr_ctrl) begin
                ctrl     <= Din[CTRL_W-1:0];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= Din;
                irq_flag <= 1'b0;
            end
        end
    end

    // Combinational read mux, independent of Sel/WE
    always_comb begin
        Dout = '0;
        case (Addr)
            ADDR_CTRL:   Dout = {(DATA_W-CTRL_W)'(0), ctrl};
            ADDR_PRESET: Dout = preset;
            ADDR_COUNT:  Dout = count;
            ADDR_STATUS: begin
`ifdef TIMER_IRQ_STATUS_EN
                Dout = {(DATA_W-1)'(0), irq_flag};
`else
                Dout = '0;
`endif
            end
            default:     Dout = '0;
        endcase
    end

    assign IRQ = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: self-checking bench for timer_dev. Directed scenario tasks
// followed by a randomized bus run checked against a behavioural model.
`timescale 1ns/1ps

module tb_timer_dev;

    localparam logic [31:0] RP = 32'h0000_00A5;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Sel;
    logic        WE;
    logic [1:0]  Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    timer_dev #(.RESET_PRESET(RP)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Sel   (Sel),
        .WE    (WE),
        .Addr  (Addr),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    // Advance past the next active edge; sampling happens 1ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        Sel  = 1'b1;
        WE   = 1'b1;
        Addr = a;
        Din  = d;
        tick();
        Sel  = 1'b0;
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    // Phases named by what the timer is doing from software's point of view.
    localparam int PH_WAITING  = 0;
    localparam int PH_ARMING   = 1;
    localparam int PH_COUNTING = 2;
    localparam int PH_FIRED    = 3;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] preset;
        logic [31:0] count;
        logic        flag;
        int          phase;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.ctrl   = 4'h0;
        m.preset = RP;
        m.count  = 32'd0;
        m.flag   = 1'b0;
        m.phase  = PH_WAITING;
        return m;
    endfunction

    function automatic model_t model_next(model_t s, logic rst, logic wr,
                                          logic [1:0] a, logic [31:0] d);
        model_t n = s;
        bit fires;
        if (rst) return model_reset();
        fires = (s.phase == PH_COUNTING) && s.ctrl[0] && (s.count <= 32'd1);
        if (s.phase == PH_WAITING) begin
            if (s.ctrl[0]) n.phase = PH_ARMING;
        end else if (s.phase == PH_ARMING) begin
            n.count = s.preset;
            n.phase = PH_COUNTING;
        end else if (s.phase == PH_COUNTING) begin
            if (!s.ctrl[0]) n.phase = PH_WAITING;
            else if (fires) begin
                n.count = 32'd0;
                n.flag  = 1'b1;
                n.phase = PH_FIRED;
            end else n.count = s.count - 32'd1;
        end else begin
            if (s.ctrl[2:1] == 2'b01) n.flag = 1'b0;
            else n.ctrl[0] = 1'b0;
            n.phase = PH_WAITING;
        end
`ifdef TIMER_IRQ_STATUS_EN
        if (wr && a == 2'd3 && d[0] && !fires) n.flag = 1'b0;
`endif
        if (wr && a == 2'd0) begin
            n.ctrl = d[3:0];
            n.flag = 1'b0;
        end
        if (wr && a == 2'd1) begin
            n.preset = d;
            n.flag   = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [31:0] model_read(model_t s, logic [1:0] a);
        case (a)
            2'd0: return {28'd0, s.ctrl};
            2'd1: return s.preset;
            2'd2: return s.count;
`ifdef TIMER_IRQ_STATUS_EN
            default: return {31'd0, s.flag};
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        rd(2'd0, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got %h want %h", v, 32'd0); end
        rd(2'd1, v);
        n_tests++; if (v !== RP) begin n_fail++; $display("FAIL reset_preset got %h want %h", v, RP); end
        rd(2'd2, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_count got %h want %h", v, 32'd0); end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", IRQ); end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);          // edge k
        tick(); tick();                  // after k+2
        rd(2'd2, v);
        n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL oneshot_count_k2 got %0d want 5", v); end
        repeat (4) tick();               // after k+6
        rd(2'd2, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL oneshot_count_k6 got %0d want 1", v); end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_k6 got %b want 0", IRQ); end
        tick();                          // after k+7
        rd(2'd2, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL oneshot_count_k7 got %0d want 0", v); end
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_k7 got %b want 1", IRQ); end
        tick();                          // after k+8
        rd(2'd0, v);
        n_tests++; if (v !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl_k8 got %h want 8", v); end
        repeat (3) tick();
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_held got %b want 1", IRQ); end
        rd(2'd2, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL oneshot_count_stays got %0d want 0", v); end
        bus_write(2'd0, 32'h8);
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_cleared got %b want 0", IRQ); end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        logic        exp_irq;
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);          // edge k
        for (int c = 1; c <= 26; c++) begin
            tick();
            exp_irq = (c >= 5) && (((c - 5) % 6) == 0);
            n_tests++;
            if (IRQ !== exp_irq) begin
                n_fail++;
                $display("FAIL autoreload_irq cycle %0d got %b want %b", c, IRQ, exp_irq);
            end
            rd(2'd2, v);
            n_tests++;
            if (v > 32'd3) begin
                n_fail++;
                $display("FAIL autoreload_count_range cycle %0d got %h want <=3", c, v);
            end
        end
    endtask

    task automatic test_masked();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h1);          // edge k, IM=0
        repeat (12) tick();              // after k+12: flag set
        rd(2'd2, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL masked_count got %0d want 0", v); end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL masked_irq got %b want 0", IRQ); end
`ifdef TIMER_IRQ_STATUS_EN
        rd(2'd3, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL masked_status got %h want 1", v); end
`endif
        tick(); tick();
        bus_write(2'd0, 32'h8);
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL masked_unmask_irq got %b want 0", IRQ); end
    endtask

    task automatic test_midcount();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd20);
        bus_write(2'd0, 32'h1);
        v = 32'hFFFF_FFFF;
        for (int i = 0; i < 40 && v != 32'd15; i++) begin
            tick();
            rd(2'd2, v);
        end
        n_tests++; if (v !== 32'd15) begin n_fail++; $display("FAIL midcount_reach15 got %0d want 15", v); end
        bus_write(2'd1, 32'd2);
        rd(2'd2, v);
        n_tests++; if (v !== 32'd14) begin n_fail++; $display("FAIL midcount_14 got %0d want 14", v); end
        tick();
        rd(2'd2, v);
        n_tests++; if (v !== 32'd13) begin n_fail++; $display("FAIL midcount_13 got %0d want 13", v); end
        tick(); tick();                  // count now 11
        bus_write(2'd0, 32'h0);          // last decrement lands on 10
        rd(2'd2, v);
        n_tests++; if (v !== 32'd10) begin n_fail++; $display("FAIL midcount_disable got %0d want 10", v); end
        repeat (4) tick();
        rd(2'd2, v);
        n_tests++; if (v !== 32'd10) begin n_fail++; $display("FAIL midcount_hold got %0d want 10", v); end
        bus_write(2'd0, 32'h1);          // edge j
        tick(); tick();                  // after j+2
        rd(2'd2, v);
        n_tests++; if (v !== 32'd2) begin n_fail++; $display("FAIL midcount_reload got %0d want 2", v); end
    endtask

    task automatic test_preset_zero();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);          // edge k
        tick(); tick();
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL preset0_irq_k2 got %b want 0", IRQ); end
        tick();                          // after k+3
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL preset0_irq_k3 got %b want 1", IRQ); end
        rd(2'd2, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL preset0_count got %h want 0", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h9);          // edge k
        for (int i = 0; i < 10 && IRQ !== 1'b1; i++) tick();
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL b2b_irq_rise got %b want 1", IRQ); end
        bus_write(2'd0, 32'h9);          // lands in the INT cycle
        rd(2'd0, v);
        n_tests++; if (v !== 32'h9) begin n_fail++; $display("FAIL b2b_ctrl_kept got %h want 9", v); end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL b2b_irq_cleared got %b want 0", IRQ); end
        tick(); tick();
        rd(2'd2, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL b2b_reloaded got %0d want 1", v); end
    endtask

    task automatic test_reset_in_int();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h9);
        for (int i = 0; i < 10 && IRQ !== 1'b1; i++) tick();
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL rstint_irq_before got %b want 1", IRQ); end
        do_reset();
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rstint_irq got %b want 0", IRQ); end
        rd(2'd0, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL rstint_ctrl got %h want 0", v); end
        rd(2'd2, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL rstint_count got %h want 0", v); end
        rd(2'd1, v);
        n_tests++; if (v !== RP) begin n_fail++; $display("FAIL rstint_preset got %h want %h", v, RP); end
    endtask

    task automatic test_status();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (8) tick();               // one-shot fired and held
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL status_irq_held got %b want 1", IRQ); end
`ifdef TIMER_IRQ_STATUS_EN
        rd(2'd3, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL status_read got %h want 1", v); end
        bus_write(2'd3, 32'h0);
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL status_noop got %b want 1", IRQ); end
        bus_write(2'd3, 32'h1);
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL status_clear got %b want 0", IRQ); end
        rd(2'd3, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL status_read_clr got %h want 0", v); end
`else
        rd(2'd3, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL addr3_read got %h want 0", v); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL addr3_write_ignored got %b want 1", IRQ); end
`endif
    endtask

    task automatic test_random();
        model_t      m;
        logic        r_rst;
        logic        r_wr;
        logic [1:0]  r_a;
        logic [31:0] r_d;
        logic [31:0] exp_d;
        logic        exp_irq;
        do_reset();
        m = model_reset();
        for (int c = 0; c < 800; c++) begin
            r_rst = ($urandom_range(0, 149) == 0);
            r_wr  = ($urandom_range(0, 9) < 3);
            r_a   = 2'($urandom_range(0, 3));
            if (r_a == 2'd1) r_d = 32'($urandom_range(0, 6));
            else r_d = $urandom;
            Reset = r_rst;
            Sel   = r_wr | ($urandom_range(0, 1) == 1);
            WE    = r_wr;
            if (!Sel) WE = 1'b0;
            r_wr  = Sel & WE;
            Addr  = r_a;
            Din   = r_d;
            m = model_next(m, r_rst, r_wr, r_a, r_d);
            tick();
            exp_d   = model_read(m, r_a);
            exp_irq = m.flag & m.ctrl[3];
            n_tests++;
            if (Dout !== exp_d) begin
                n_fail++;
                $display("FAIL random_dout cycle %0d addr %0d got %h want %h", c, r_a, Dout, exp_d);
            end
            n_tests++;
            if (IRQ !== exp_irq) begin
                n_fail++;
                $display("FAIL random_irq cycle %0d got %b want %b", c, IRQ, exp_irq);
            end
        end
        Reset = 1'b0;
        Sel   = 1'b0;
        WE    = 1'b0;
        Din   = '0;
    endtask

    initial begin
        Reset = 1'b1;
        Sel   = 1'b0;
        WE    = 1'b0;
        Addr  = 2'd0;
        Din   = '0;
        tick();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_midcount();
        test_preset_zero();
        test_back_to_back();
        test_reset_in_int();
        test_status();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
